// File: rtl/gf_inv_2027.sv
`default_nettype none
// ============================================================================
//  Module   : gf_inv_2027
//  Brief    : Sequential modular inverter for GF(Q), r = a^(Q-2) mod Q, using
//             left-to-right square-and-multiply over one Barrett multiplier
//             (one modular multiply per clock).
//  Revision : 1.0  - initial release
// ============================================================================
module gf_inv_2027 #(
    parameter int Q  = 2027,   // field prime
    parameter int QW = 11,     // element width, Q < 2^QW < 2Q
    parameter int MU = 2069    // floor(2^(2*QW) / Q)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] in_a,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] out_r,
    output logic          out_err
);

    localparam int IW = $clog2(QW);       // bit-index width
    localparam int XW = 2 * QW;           // full product width
    localparam int TW = 2 * QW + 2;       // Barrett intermediate width

    localparam logic [QW-1:0] c_q     = QW'(Q);
    localparam logic [QW-1:0] c_exp   = QW'(Q - 2);   // Fermat exponent
    localparam logic [TW-1:0] c_q_w   = TW'(Q);
    localparam logic [TW-1:0] c_mu_w  = TW'(MU);
    localparam logic [IW-1:0] c_idx_top = IW'(QW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [QW-1:0] r_acc;
    logic [QW-1:0] r_base;
    logic [IW-1:0] r_idx;
    logic          r_err;

    state_t        w_state_nxt;
    logic [QW-1:0] w_acc_nxt;
    logic [QW-1:0] w_base_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic          w_err_nxt;

    logic [QW-1:0] w_a_red;
    logic [QW-1:0] w_mul_b;
    logic [XW-1:0] w_x;
    logic [TW-1:0] w_prod;
    logic [TW-1:0] w_t;
    logic [TW-1:0] w_r0;
    logic [TW-1:0] w_r1;
    logic [QW-1:0] w_mm;

    // Handshake outputs; the result is only presented while in DONE.
    assign in_ready  = rst_n && (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_r     = (r_state == DONE && !r_err) ? r_acc : '0;
    assign out_err   = (r_state == DONE) && r_err;

    // Operand may be in [Q, 2^QW); one subtract brings it into the field.
    assign w_a_red = (in_a >= c_q) ? (in_a - c_q) : in_a;

    // Barrett modular multiply: acc * (base in MUL, acc in SQR) mod Q.
    always_comb begin
        w_mul_b = (r_state == MUL) ? r_base : r_acc;
        w_x     = XW'(r_acc) * XW'(w_mul_b);
        w_prod  = TW'(w_x >> (QW - 1)) * c_mu_w;
        w_t     = w_prod >> (QW + 1);
        // Quotient estimate undershoots by at most two, so r0 < 3Q.
        w_r0    = TW'(w_x) - (w_t * c_q_w);
        w_r1    = (w_r0 >= c_q_w) ? (w_r0 - c_q_w) : w_r0;
        w_mm    = QW'((w_r1 >= c_q_w) ? (w_r1 - c_q_w) : w_r1);
    end

    // Next-state and datapath update for the square-and-multiply walk.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_base_nxt  = r_base;
        w_idx_nxt   = r_idx;
        w_err_nxt   = r_err;
        case (r_state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    w_base_nxt  = w_a_red;
                    w_acc_nxt   = QW'(1);
                    w_idx_nxt   = c_idx_top;
                    w_err_nxt   = (w_a_red == '0);
                    w_state_nxt = SQR;
                end
            end
            SQR: begin
                w_acc_nxt = w_mm;
                if (c_exp[r_idx]) begin
                    w_state_nxt = MUL;
                end else if (r_idx == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt = r_idx - IW'(1);
                end
            end
            MUL: begin
                w_acc_nxt = w_mm;
                if (r_idx == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt   = r_idx - IW'(1);
                    w_state_nxt = SQR;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any computation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_base  <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_base  <= w_base_nxt;
            r_idx   <= w_idx_nxt;
            r_err   <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gf_inv_2027.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_gf_inv_2027
//  Brief    : Self-checking bench for gf_inv_2027 (vector table, scoreboard,
//             backpressure, input stability, mid-operation reset, exhaustive).
//  Revision : 1.0  - initial release
// ============================================================================
module tb_gf_inv_2027;

    localparam int Q   = 2027;
    localparam int QW  = 11;
    localparam int LAT = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [QW-1:0] in_a = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [QW-1:0] out_r;
    logic          out_err;

    gf_inv_2027 #(.Q(Q), .QW(QW), .MU(2069)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [QW-1:0] a;
        logic [QW-1:0] r;
        logic          err;
        longint        t;
    } exp_t;

    typedef struct {
        logic [QW-1:0] a;
        logic [QW-1:0] r;
        logic          err;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   lat_done = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Independent reference: brute-force search for the inverse.
    function automatic int inv_model(input int a);
        int b;
        b = a % Q;
        if (b == 0) return 0;
        for (int x = 1; x < Q; x++) begin
            if ((b * x) % Q == 1) return x;
        end
        return -1;
    endfunction

    // Result monitor: latency of each result, then value on the handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !lat_done) begin
                lat_done = 1'b1;
                if (sb.size() == 0) check("spurious_out_valid", 0, 1);
                else                check("latency", cyc - sb[0].t, LAT);
            end
            if (out_valid && out_ready) begin
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("out_r", out_r, mon_e.r);
                    check("out_err", out_err, mon_e.err);
                    if (!mon_e.err)
                        check("a_times_r_mod_q", ((int'(mon_e.a) % Q) * int'(out_r)) % Q, 1);
                end
                lat_done = 1'b0;
            end
        end
    end

    // Present an operand until accepted, then log its expected result.
    task automatic issue(input logic [QW-1:0] a, input logic [QW-1:0] r, input logic err);
        int guard;
        exp_t e;
        guard = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a     = a;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 100) begin
                fail_now("accept");
                break;
            end
        end
        e.a = a; e.r = r; e.err = err; e.t = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                fail_now("drain");
                sb.delete();
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_valid();
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            guard++;
            if (guard > 60) begin
                fail_now("out_valid");
                break;
            end
        end
    endtask

    vec_t vt[8];

    initial begin
        int seen;
        logic [QW-1:0] inv_a;

        vt[0] = '{11'd1,    11'd1,    1'b0};
        vt[1] = '{11'd2,    11'd1014, 1'b0};
        vt[2] = '{11'd3,    11'd676,  1'b0};
        vt[3] = '{11'd2026, 11'd2026, 1'b0};
        vt[4] = '{11'd0,    11'd0,    1'b1};
        vt[5] = '{11'd2027, 11'd0,    1'b1};
        vt[6] = '{11'd2028, 11'd1,    1'b0};
        vt[7] = '{11'd5,    11'd811,  1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            issue(vt[i].a, vt[i].r, vt[i].err);
            wait_idle();
        end

        // Backpressure: hold out_ready low for 7 cycles after out_valid
        out_ready = 1'b0;
        issue(11'd5, 11'd811, 1'b0);
        wait_valid();
        for (int k = 0; k < 7; k++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_r", out_r, 811);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_after", in_ready, 1);
        check("bp_out_valid_after", out_valid, 0);
        wait_idle();

        // Input stability: wiggle in_valid/in_a while busy
        issue(11'd3, 11'd676, 1'b0);
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom_range(0, 1));
            in_a     = QW'($urandom_range(0, 2047));
            @(negedge clk);
            check("busy_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a computation
        issue(11'd200, QW'(inv_model(200)), 1'b0);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_out_r", out_r, 0);
        check("abort_out_err", out_err, 0);
        check("abort_in_ready", in_ready, 0);
        sb.delete();
        lat_done = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        check("abort_idle", in_ready, 1);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        issue(11'd2, 11'd1014, 1'b0);
        wait_idle();

        // Exhaustive sweep, issued back-to-back
        for (int a = 1; a < Q; a++) begin
            inv_a = QW'(inv_model(a));
            issue(QW'(a), inv_a, 1'b0);
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
